arbitro_wrr: RTL

- Weighted round-robin scheduler for the 4 input FIFOs of the transaction layer.
- Issues one-hot pops to the input FIFOs according to programmable per-queue weights.
- Pushes each popped word into the output FIFO selected by its dest field one cycle later.
- Stalls new pops on downstream almost-full and avoids over-popping nearly empty queues.

---
 rtl/arbitro_wrr.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/arbitro_wrr.sv
// -----------------------------------------------------------------------------
// arbitro_wrr
//   Weighted round-robin scheduler between the four input FIFOs and the four
//   output FIFOs of the transaction layer. Each queue owns a credit counter
//   loaded from its weight; a queue is served while it has credit, then the
//   scheduler moves on in circular order. When nobody eligible has credit left
//   but some queue could still be served, all credits are reloaded from the
//   weights (one idle cycle). The popped word is pushed into the output FIFO
//   named by its dest field one cycle after the pop strobe.
//
// Ports
//   clk                clock, all state on rising edge
//   reset              asynchronous active-low reset
//   Enable             1 = may schedule, 0 = freeze scheduling state
//   FIFO_empty[3:0]    input FIFO empty flags
//   FIFO_almost_empty  input FIFO "one word left" flags
//   Almost_full[3:0]   output FIFO almost-full flags (any one stalls)
//   dest[1:0]          destination of the word at the popped FIFO output
//   W0..W3             per-queue weights, sampled at reload; 0 disables queue
//   Pops[3:0]          registered one-hot pop strobe
//   Push[3:0]          one-hot push strobe, cycle after each pop
//   estado[1:0]        FSM state: 0 IDLE, 1 RUN, 2 RELOAD, 3 STALL
// -----------------------------------------------------------------------------
module arbitro_wrr #(
  parameter int WEIGHT_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Enable,
  input  logic [3:0]          FIFO_empty,
  input  logic [3:0]          FIFO_almost_empty,
  input  logic [3:0]          Almost_full,
  input  logic [1:0]          dest,
  input  logic [WEIGHT_W-1:0] W0,
  input  logic [WEIGHT_W-1:0] W1,
  input  logic [WEIGHT_W-1:0] W2,
  input  logic [WEIGHT_W-1:0] W3,
  output logic [3:0]          Pops,
  output logic [3:0]          Push,
  output logic [1:0]          estado
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] RELOAD = 2'd2;
  localparam logic [1:0] STALL  = 2'd3;

  localparam logic [WEIGHT_W-1:0] CREDIT_ONE = WEIGHT_W'(1);

  // State
  logic [WEIGHT_W-1:0] credit_q [4];
  logic [WEIGHT_W-1:0] credit_d [4];
  logic [1:0]          cur_q, cur_d;
  logic [3:0]          pops_q, pops_d;
  logic [1:0]          estado_q, estado_d;
  logic                pend_q, pend_d;

  // Combinational helpers
  logic [WEIGHT_W-1:0] weight [4];
  logic [3:0]          last_pop;
  logic [3:0]          elig;
  logic [3:0]          ready;
  logic [3:0]          elig_rot;
  logic [1:0]          grant_ofs;
  logic [1:0]          grant;

  // The pop strobe registered at the previous edge is exactly the "last pop"
  // whose effect the FIFO flags do not show yet, so no separate flop is kept.
  assign last_pop = pops_q;

  // Lowest set bit of a 4-bit vector (0 when empty; callers check |v first).
  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  always_comb begin
    weight[0] = W0;
    weight[1] = W1;
    weight[2] = W2;
    weight[3] = W3;

    for (int i = 0; i < 4; i++) begin
      elig[i]  = !FIFO_empty[i] && (credit_q[i] != '0)
                 && !(last_pop[i] && FIFO_almost_empty[i]);
      ready[i] = !FIFO_empty[i] && (weight[i] != '0)
                 && !(last_pop[i] && FIFO_almost_empty[i]);
    end

    // Rotate eligibility so bit 0 is the current queue; the first set bit of
    // the rotated vector is the offset of the grant from cur.
    for (int k = 0; k < 4; k++) begin
      elig_rot[k] = elig[cur_q + 2'(k)];
    end
    grant_ofs = first_set(elig_rot);
    grant     = cur_q + grant_ofs;
  end

  // Next-state decision, first match wins.
  always_comb begin
    // NOTE: every signal gets a default before the if/else chain so that no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    pops_d   = '0;
    cur_d    = cur_q;
    estado_d = estado_q;
    for (int i = 0; i < 4; i++) credit_d[i] = credit_q[i];

    if (!Enable) begin
      // Frozen: credits, cur and state hold, no pop.
    end else if (|Almost_full) begin
      estado_d = STALL;
    end else if (|elig) begin
      pops_d          = 4'b0001 << grant;
      credit_d[grant] = credit_q[grant] - CREDIT_ONE;
      cur_d           = grant;
      estado_d        = RUN;
    end else if (|ready) begin
      for (int i = 0; i < 4; i++) credit_d[i] = weight[i];
      cur_d    = 2'd0;
      estado_d = RELOAD;
    end else begin
      estado_d = IDLE;
    end

    // The word for a pop strobed during this cycle appears at the FIFO output
    // next cycle, so the push is scheduled from the registered strobe. It is
    // not gated by Enable or Almost_full: a started transfer always finishes.
    pend_d = |pops_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge regardless of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pops_q   <= '0;
      cur_q    <= '0;
      estado_q <= IDLE;
      pend_q   <= 1'b0;
      // NOTE: the credit array is four small counters, not a RAM, and its
      // zero value after reset is what forces the first action to be a
      // reload, so it is reset along with the rest of the state.
      for (int i = 0; i < 4; i++) credit_q[i] <= '0;
    end else begin
      pops_q   <= pops_d;
      cur_q    <= cur_d;
      estado_q <= estado_d;
      pend_q   <= pend_d;
      for (int i = 0; i < 4; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign Pops   = pops_q;
  assign estado = estado_q;
  // pend_q clears asynchronously, so a pending push disappears with reset.
  assign Push   = pend_q ? (4'b0001 << dest) : 4'b0000;

endmodule
